// File: rtl/top_arb_grid.sv
// ---------------------------------------------------------------------------
// top_arb_grid
//
// Two-level round-robin arbiter for a ROWS x COLS grid of polarity-tagged
// event requests. Each cycle at most one cell is granted: the first active
// row at or after row_ptr is chosen, then the first active cell in that row
// at or after that row's own column pointer. Pointers advance past the
// granted row/cell, so a cell that keeps requesting is served within
// ROWS*COLS grants.
//
// Ports
//   clk_i       in   1                         rising-edge clock
//   reset_i     in   1                         synchronous, active-high
//   enable_i    in   1                         1 = arbitrate, 0 = no grant, pointers hold
//   req_i       in   [COLS-1:0][POLARITY-1:0] x [ROWS-1:0]
//                                              per-cell requests, bit1 = ON, bit0 = OFF
//   gnt_o       out  [ROWS-1:0][COLS-1:0]      one-hot grant, zero when nothing granted
//   polarity_o  out  1                         1 = ON event granted, 0 = OFF (or no grant)
//
// Configuration macro
//   ARB_GRANT_REG_EN  defined   : gnt_o/polarity_o registered, 1-cycle latency,
//                                 reset to 0. Pointer behaviour unchanged.
//                     undefined : gnt_o/polarity_o combinational (default).
// ---------------------------------------------------------------------------
module top_arb_grid #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int POLARITY = 2
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [COLS-1:0][POLARITY-1:0]      req_i [ROWS-1:0],
  output logic [ROWS-1:0][COLS-1:0]          gnt_o,
  output logic                               polarity_o
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // Bit of each cell's request field that marks an ON event; ON wins when
  // both polarities are requested at once.
  localparam int ON_BIT = 1;

  // Round-robin pick helpers: first set bit of act scanning upward from ptr,
  // wrapping at the top. The result is only meaningful when act is non-zero;
  // callers qualify it with an any-active flag.
  function automatic logic [RW-1:0] pick_row(input logic [ROWS-1:0] act,
                                             input logic [RW-1:0]   ptr);
    logic [RW-1:0] sel;
    logic          hit;
    int            idx;
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= ROWS) idx = idx - ROWS;
      if (!hit && act[RW'(idx)]) begin
        sel = RW'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [CW-1:0] pick_col(input logic [COLS-1:0] act,
                                             input logic [CW-1:0]   ptr);
    logic [CW-1:0] sel;
    logic          hit;
    int            idx;
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < COLS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= COLS) idx = idx - COLS;
      if (!hit && act[CW'(idx)]) begin
        sel = CW'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  // Modulo increments; written as compare-and-wrap so non-power-of-two
  // grid sizes wrap correctly.
  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] p);
    return (p == RW'(ROWS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] next_col(input logic [CW-1:0] p);
    return (p == CW'(COLS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration state
  logic [RW-1:0]             row_ptr;
  logic [CW-1:0]             col_ptr [ROWS-1:0];

  // Request activity
  logic [ROWS-1:0][COLS-1:0] cell_act;
  logic [ROWS-1:0]           row_act;

  // Combinational grant result
  logic [RW-1:0]             sel_row;
  logic [CW-1:0]             sel_col;
  logic                      vld_p0;
  logic [ROWS-1:0][COLS-1:0] gnt_p0;
  logic                      pol_p0;

  always_comb begin
    cell_act = '0;
    row_act  = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cell_act[r][c] = |req_i[r][c];
      end
      row_act[r] = |cell_act[r];
    end
  end

  // ---- stage p0: row pick, column pick, one-hot grant ----
  always_comb begin
    sel_row = pick_row(row_act, row_ptr);
    sel_col = pick_col(cell_act[sel_row], col_ptr[sel_row]);
  end

  // A grant exists whenever any row is active; reset and enable gate it so
  // the outputs are quiet while held in reset or disabled.
  always_comb begin
    vld_p0 = enable_i & ~reset_i & (|row_act);
    gnt_p0 = '0;
    pol_p0 = 1'b0;
    if (vld_p0) begin
      gnt_p0[sel_row][sel_col] = 1'b1;
      pol_p0                   = req_i[sel_row][sel_col][ON_BIT];
    end
  end

  // Pointer update follows the grant present at the edge. Only the granted
  // row's column pointer moves; other rows keep their position.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_ptr <= '0;
      for (int r = 0; r < ROWS; r++) begin
        col_ptr[r] <= '0;
      end
    end else if (vld_p0) begin
      row_ptr          <= next_row(sel_row);
      col_ptr[sel_row] <= next_col(sel_col);
    end
  end

`ifdef ARB_GRANT_REG_EN
  // ---- stage p1: registered grant outputs ----
  logic [ROWS-1:0][COLS-1:0] gnt_p1;
  logic                      pol_p1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gnt_p1 <= '0;
      pol_p1 <= 1'b0;
    end else begin
      gnt_p1 <= gnt_p0;
      pol_p1 <= pol_p0;
    end
  end

  assign gnt_o      = gnt_p1;
  assign polarity_o = pol_p1;
`else
  assign gnt_o      = gnt_p0;
  assign polarity_o = pol_p0;
`endif

endmodule

// File: tb/tb_top_arb_grid.sv
// ---------------------------------------------------------------------------
// tb_top_arb_grid
//
// Directed bench for top_arb_grid (combinational-grant build). The stimulus
// process drives req_i/enable_i/reset_i just after each rising edge and
// pushes the hand-derived grant for that cycle into a queue; the monitor
// pops one entry per falling edge and compares gnt_o/polarity_o.
// ---------------------------------------------------------------------------
module tb_top_arb_grid;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int POLARITY = 2;

  logic                          clk;
  logic                          reset;
  logic                          enable;
  logic [COLS-1:0][POLARITY-1:0] req [ROWS-1:0];
  logic [ROWS-1:0][COLS-1:0]     gnt;
  logic                          pol;

  top_arb_grid #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .POLARITY (POLARITY)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .enable_i   (enable),
    .req_i      (req),
    .gnt_o      (gnt),
    .polarity_o (pol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [ROWS*COLS-1:0] exp_g_q [$];
  logic                 exp_p_q [$];
  int                   tag_q   [$];
  int                   checks = 0;
  int                   errors = 0;
  int                   tag    = 0;

  logic [ROWS*COLS-1:0] mon_g;
  logic                 mon_p;
  int                   mon_t;

  task automatic expect_grant(input int r, input int c, input logic p);
    logic [ROWS*COLS-1:0] m;
    m            = '0;
    m[r*COLS+c]  = 1'b1;
    exp_g_q.push_back(m);
    exp_p_q.push_back(p);
    tag_q.push_back(tag);
    tag++;
  endtask

  task automatic expect_none();
    exp_g_q.push_back('0);
    exp_p_q.push_back(1'b0);
    tag_q.push_back(tag);
    tag++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    for (int r = 0; r < ROWS; r++) begin
      req[r] = '0;
    end
  endtask

  // Monitor: one comparison per queued expectation, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_g_q.size() > 0) begin
      mon_g = exp_g_q.pop_front();
      mon_p = exp_p_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (gnt !== mon_g || pol !== mon_p) begin
        errors++;
        $display("FAIL vec%0d: got gnt=%h pol=%b, required gnt=%h pol=%b",
                 mon_t, gnt, pol, mon_g, mon_p);
      end
    end
  end

  // Hard stop in case the stimulus never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    clear_req();
    tick();

    // Reset held with requests present: outputs must stay quiet.
    req[0][0] = 2'b01; req[0][1] = 2'b10; req[0][2] = 2'b10; req[0][3] = 2'b00;
    req[0][4] = 2'b01; req[0][5] = 2'b00; req[0][6] = 2'b01; req[0][7] = 2'b10;
    expect_none(); tick();
    expect_none(); tick();

    // Row 0 sweep, bench clears each request once granted.
    reset = 1'b0;
    expect_grant(0, 0, 1'b0); tick(); req[0][0] = 2'b00;
    expect_grant(0, 1, 1'b1); tick(); req[0][1] = 2'b00;
    expect_grant(0, 2, 1'b1); tick(); req[0][2] = 2'b00;
    expect_grant(0, 4, 1'b0); tick(); req[0][4] = 2'b00;
    expect_grant(0, 6, 1'b0); tick(); req[0][6] = 2'b00;
    expect_grant(0, 7, 1'b1); tick(); req[0][7] = 2'b00;
    expect_none(); tick();

    // Rows 1, 2, 5 active from zeroed pointers; requests held.
    reset = 1'b1;
    req[1][1] = 2'b10; req[1][3] = 2'b01; req[2][0] = 2'b10; req[5][7] = 2'b11;
    expect_none(); tick();
    reset = 1'b0;
    expect_grant(1, 1, 1'b1); tick();
    expect_grant(2, 0, 1'b1); tick();
    expect_grant(5, 7, 1'b1); tick();
    expect_grant(1, 3, 1'b0); tick();   // wrap 6,7,0,1; row 1 column pointer at 2
    expect_grant(2, 0, 1'b1); tick();   // column pointer 1 wraps back to 0

    // Mid-sequence reset: without it the next grant would be [5][7].
    reset = 1'b1;
    expect_none(); tick();
    reset = 1'b0;
    expect_grant(1, 1, 1'b1); tick();
    expect_grant(2, 0, 1'b1); tick();   // row_ptr now 3

    // Dense pattern with enable low: no grants, pointers hold.
    enable = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        req[r][c] = 2'b11;
      end
    end
    for (int i = 0; i < 10; i++) begin
      expect_none(); tick();
    end
    enable = 1'b1;
    expect_grant(3, 0, 1'b1); tick();
    expect_grant(4, 0, 1'b1); tick();

    // Lone held request is granted every cycle.
    clear_req();
    req[3][6] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      expect_grant(3, 6, 1'b0); tick();
    end

    // Both polarities requested: ON wins.
    clear_req();
    req[2][3] = 2'b11;
    expect_grant(2, 3, 1'b1); tick();

    // Nothing requested.
    clear_req();
    expect_none(); tick();
    tick();
    tick();

    // Every queued expectation must have been consumed.
    checks++;
    if (exp_g_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_g_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
